mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width.
REQ-002 Parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  MEM stage presents a load/store.
REQ-006 req_wr  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-008 req_signed  input  1  sign-extend load result.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 req_ready  output  1  request accepted this cycle.
REQ-012 resp_valid  output  1  one-cycle pulse: access complete.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores.
REQ-014 stallreq  output  1  pipeline stall request to stall controller.
REQ-015 misalign  output  1  one-cycle pulse: rejected misaligned access.
REQ-016 data_sram_en  output  1  SRAM request strobe.
REQ-017 data_sram_wen  output  4  byte write enables.
REQ-018 data_sram_addr  output  ADDR_W  word-aligned address (low 2 bits 0).
REQ-019 data_sram_wdata  output  32  byte-lane-replicated store data.
REQ-020 data_sram_addr_ok  input  1  SRAM accepted address.
REQ-021 data_sram_data_ok  input  1  SRAM completed access; rdata valid.
REQ-022 data_sram_rdata  input  32  raw word read.

Function
REQ-023 FSM states IDLE, ADDR, DATA, RESP; one access outstanding max.
REQ-024 IDLE & req_valid & aligned: latch request, req_ready=1, go ADDR.
REQ-025 ADDR: data_sram_en=1 with latched addr/wen/wdata; on addr_ok go DATA; else hold all SRAM outputs stable.
REQ-026 DATA: data_sram_en=0; on data_ok capture rdata, go RESP.
REQ-027 addr_ok and data_ok same cycle in ADDR: go directly RESP.
REQ-028 RESP: resp_valid=1 for exactly one cycle, return IDLE; new request accepted no earlier than following cycle.
REQ-029 Minimum latency req_ready to resp_valid: 2 cycles (addr_ok and data_ok both same cycle).
REQ-030 stallreq=1 whenever req_valid=1 and state is not RESP; 0 in RESP and when idle without request.
REQ-031 wen: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111; loads -> 0.
REQ-032 wdata: byte replicated 4x, half replicated 2x, word unchanged.
REQ-033 Load extraction selects lane by latched addr[1:0], zero- or sign-extends per req_signed.
REQ-034 Aligned: byte always; half addr[0]=0; word addr[1:0]=00; req_size 11 treated as word.
REQ-035 data_ok in IDLE or ADDR without addr_ok is ignored.

Reset
REQ-036 rst asserted: state=IDLE immediately; all outputs 0, including mid-access (outstanding SRAM response after reset discarded).
REQ-037 Latched request registers reset to 0.

Configuration
REQ-038 Macro MEM_MISALIGN_TRAP_EN defined: misaligned request in IDLE is not issued, misalign pulses one cycle, req_ready=1, stallreq=0 that cycle, state stays IDLE.
REQ-039 Macro undefined: misalign tied 0; misaligned addresses have low bits forced to natural alignment and proceed normally.

Structure
REQ-040 State encodings, size codes, and the 32-bit lane constants live in the shared defines header alongside stall/bus widths.
REQ-041 One sub-module, mem_lane_align: purely combinational wen/wdata generation and load extraction; FSM stays in top.

Verification
REQ-042 Word store addr 0x100, wdata 0xDEADBEEF, addr_ok cycle1, data_ok cycle1 -> wen 1111, sram addr 0x100, resp_valid cycle 2, resp_rdata 0.
REQ-043 Signed byte load addr 0x103, rdata 0x80112233, addr_ok delayed 3 cycles, data_ok 2 later -> stallreq high throughout, resp_rdata 0xFFFFFF80.
REQ-044 Unsigned half load addr 0x202, rdata 0xABCD1234 -> resp_rdata 0x0000ABCD; half store 0x5678 addr 0x202 -> wen 1100, wdata 0x56785678.
REQ-045 rst asserted in DATA, data_ok arrives after deassert -> no resp_valid, state IDLE, outputs 0.
REQ-046 With MEM_MISALIGN_TRAP_EN: word load addr 0x101 -> misalign pulse, data_sram_en never 1; without: access issued at 0x100.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state
// encoding, request size codes, 32-bit byte-lane constants and the
// stall/bus widths, plus small helpers for size normalisation and alignment.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam int WORD_W     = 32;
   localparam int BYTE_LANES = 4;
   localparam int LANE_OFF_W = 2;
   localparam int STALL_W    = 1;

   localparam logic [BYTE_LANES-1:0] WEN_NONE = 4'b0000;
   localparam logic [BYTE_LANES-1:0] WEN_BYTE = 4'b0001;
   localparam logic [BYTE_LANES-1:0] WEN_HALF = 4'b0011;
   localparam logic [BYTE_LANES-1:0] WEN_WORD = 4'b1111;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == SIZE_RSVD) ? SIZE_WORD : size;
   endfunction

   // True when the low address bits suit the natural alignment of the size.
   function automatic logic is_aligned(input logic [1:0] size,
                                       input logic [LANE_OFF_W-1:0] off);
      case (norm_size(size))
         SIZE_BYTE: return 1'b1;
         SIZE_HALF: return ~off[0];
         default:   return (off == 2'b00);
      endcase
   endfunction

   // Forces the byte offset down to the natural alignment of the size.
   function automatic logic [LANE_OFF_W-1:0] align_off(input logic [1:0] size,
                                                       input logic [LANE_OFF_W-1:0] off);
      case (norm_size(size))
         SIZE_BYTE: return off;
         SIZE_HALF: return {off[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: builds store write enables
// and lane-replicated store data, and extracts/extends a loaded value from
// a raw 32-bit SRAM word. Purely combinational.
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]            st_size,
   input  logic [LANE_OFF_W-1:0] st_off,
   input  logic                  st_wr,
   input  logic [WORD_W-1:0]     st_wdata,
   output logic [BYTE_LANES-1:0] st_wen,
   output logic [WORD_W-1:0]     st_lanes,
   input  logic [1:0]            ld_size,
   input  logic [LANE_OFF_W-1:0] ld_off,
   input  logic                  ld_signed,
   input  logic [WORD_W-1:0]     ld_rdata,
   output logic [WORD_W-1:0]     ld_data
);

   logic [1:0]            st_sz;
   logic [LANE_OFF_W-1:0] st_al;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   // Store side: enable only the lanes the access covers and replicate the
   // LSB-aligned data across every lane so the SRAM sees it on any lane.
   always_comb begin
      st_sz    = norm_size(st_size);
      st_al    = align_off(st_size, st_off);
      st_wen   = WEN_NONE;
      st_lanes = '0;
      if (st_wr) begin
         case (st_sz)
            SIZE_BYTE: begin
               st_wen   = WEN_BYTE << st_al;
               st_lanes = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
               st_wen   = WEN_HALF << st_al;
               st_lanes = {2{st_wdata[15:0]}};
            end
            default: begin
               st_wen   = WEN_WORD;
               st_lanes = st_wdata;
            end
         endcase
      end
   end

   // Load side: pick the addressed lane(s) and zero- or sign-extend.
   always_comb begin
      case (ld_off)
         2'd0:    ld_byte = ld_rdata[7:0];
         2'd1:    ld_byte = ld_rdata[15:8];
         2'd2:    ld_byte = ld_rdata[23:16];
         default: ld_byte = ld_rdata[31:24];
      endcase
      ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      case (ld_size)
         SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
         SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
         default:   ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Accepts one load/store at a time,
// runs the two-phase (address / data) SRAM handshake, returns extended load
// data with a one-cycle response pulse and raises stallreq while busy.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned requests are rejected
// with a one-cycle misalign pulse instead of being silently aligned down.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_wr,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic [STALL_W-1:0]    stallreq,
   output logic                  misalign,
   output logic                  data_sram_en,
   output logic [BYTE_LANES-1:0] data_sram_wen,
   output logic [ADDR_W-1:0]     data_sram_addr,
   output logic [DATA_W-1:0]     data_sram_wdata,
   input  logic                  data_sram_addr_ok,
   input  logic                  data_sram_data_ok,
   input  logic [DATA_W-1:0]     data_sram_rdata
);

   state_t                state;
   logic                  lat_wr;
   logic [1:0]            lat_size;
   logic                  lat_signed;
   logic [LANE_OFF_W-1:0] lat_off;
   logic                  accept;
   logic                  trap;
   logic [BYTE_LANES-1:0] st_wen;
   logic [WORD_W-1:0]     st_lanes;
   logic [WORD_W-1:0]     ld_data;

   mem_lane_align u_lane (
      .st_size   (req_size),
      .st_off    (req_addr[1:0]),
      .st_wr     (req_wr),
      .st_wdata  (req_wdata),
      .st_wen    (st_wen),
      .st_lanes  (st_lanes),
      .ld_size   (lat_size),
      .ld_off    (lat_off),
      .ld_signed (lat_signed),
      .ld_rdata  (data_sram_rdata),
      .ld_data   (ld_data)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   logic aligned;

   // Misaligned requests seen in IDLE are acknowledged as a trap, never issued.
   always_comb begin
      aligned = is_aligned(req_size, req_addr[1:0]);
      trap    = (state == ST_IDLE) & req_valid & ~aligned;
      accept  = (state == ST_IDLE) & req_valid & aligned;
   end
`else
   // Every request is accepted in IDLE; misaligned ones are aligned down.
   always_comb begin
      trap   = 1'b0;
      accept = (state == ST_IDLE) & req_valid;
   end
`endif

   // Handshake toward the pipeline: ready on accept or trap, stall while a
   // request is pending anywhere except the response cycle.
   always_comb begin
      req_ready = accept | trap;
      misalign  = trap;
      stallreq  = req_valid & (state != ST_RESP) & ~trap;
   end

   // Access FSM: latch the request, hold SRAM outputs until addr_ok, wait for
   // data_ok, then pulse the response for exactly one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         lat_wr          <= 1'b0;
         lat_size        <= SIZE_BYTE;
         lat_signed      <= 1'b0;
         lat_off         <= '0;
         data_sram_en    <= 1'b0;
         data_sram_wen   <= WEN_NONE;
         data_sram_addr  <= '0;
         data_sram_wdata <= '0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               resp_rdata <= '0;
               if (accept) begin
                  lat_wr          <= req_wr;
                  lat_size        <= norm_size(req_size);
                  lat_signed      <= req_signed;
                  lat_off         <= align_off(req_size, req_addr[1:0]);
                  data_sram_en    <= 1'b1;
                  data_sram_wen   <= st_wen;
                  data_sram_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                  data_sram_wdata <= st_lanes;
                  state           <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (data_sram_addr_ok) begin
                  data_sram_en <= 1'b0;
                  if (data_sram_data_ok) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= lat_wr ? '0 : ld_data;
                     state      <= ST_RESP;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (data_sram_data_ok) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= lat_wr ? '0 : ld_data;
                  state      <= ST_RESP;
               end
            end
            default: begin
               resp_rdata <= '0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. The bench plays both the MEM stage
// and the data SRAM, and predicts every observable value from the access
// rules using plain arithmetic on sizes and byte offsets.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        stallreq;
   logic        misalign;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   int total = 0;
   int bad   = 0;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_wr            (req_wr),
      .req_size          (req_size),
      .req_signed        (req_signed),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_ready         (req_ready),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .stallreq          (stallreq),
      .misalign          (misalign),
      .data_sram_en      (data_sram_en),
      .data_sram_wen     (data_sram_wen),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: number of bytes touched (reserved size behaves as a word).
   function automatic int refBytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // Reference: byte offset rounded down to the access's natural alignment.
   function automatic int refOff(input logic [1:0] size, input logic [31:0] addr);
      int n;
      n = refBytes(size);
      return ((addr % 4) / n) * n;
   endfunction

   function automatic logic [3:0] refWen(input logic wr, input logic [1:0] size, input logic [31:0] addr);
      int n;
      n = refBytes(size);
      if (!wr) return 4'b0000;
      return 4'(((1 << n) - 1) << refOff(size, addr));
   endfunction

   function automatic logic [31:0] refWdata(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = refBytes(size);
      r = 32'h0;
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] refLoad(input logic wr, input logic [1:0] size, input logic sgn,
                                           input logic [31:0] addr, input logic [31:0] raw);
      logic [31:0] mask;
      logic [31:0] v;
      int bits;
      if (wr) return 32'h0;
      bits = 8 * refBytes(size);
      mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 1);
      v    = (raw >> (8 * refOff(size, addr))) & mask;
      if (sgn && bits < 32 && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit refMisaligned(input logic [1:0] size, input logic [31:0] addr);
      return (addr % refBytes(size)) != 0;
   endfunction

   // Drives one request and acts as the SRAM: addr_ok after aokDelay wait
   // cycles, data_ok dokDelay cycles after the addr_ok cycle (0 = same cycle).
   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] raw, input int aokDelay, input int dokDelay);
      logic [3:0]  expWen;
      logic [31:0] expAddr;
      logic [31:0] expWd;
      logic [31:0] expRd;
      bit          trapIt;
      expWen  = refWen(wr, size, addr);
      expAddr = addr & 32'hFFFF_FFFC;
      expWd   = refWdata(size, wd);
      expRd   = refLoad(wr, size, sgn, addr, raw);
`ifdef MEM_MISALIGN_TRAP_EN
      trapIt = refMisaligned(size, addr);
`else
      trapIt = 1'b0;
`endif
      req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      @(negedge clk);
      checkOutput("accept_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("accept_stall", {31'h0, stallreq}, {31'h0, ~trapIt});
      checkOutput("accept_misalign", {31'h0, misalign}, {31'h0, trapIt});
      @(posedge clk); #1;
      if (trapIt) begin
         req_valid = 1'b0;
         @(negedge clk);
         checkOutput("trap_no_en", {31'h0, data_sram_en}, 32'h0);
         checkOutput("trap_pulse_end", {31'h0, misalign}, 32'h0);
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i < aokDelay; i++) begin
         data_sram_addr_ok = 1'b0;
         data_sram_data_ok = 1'($urandom_range(0, 1));
         data_sram_rdata   = $urandom;
         @(negedge clk);
         checkOutput("wait_en", {31'h0, data_sram_en}, 32'h1);
         checkOutput("wait_wen", {28'h0, data_sram_wen}, {28'h0, expWen});
         checkOutput("wait_addr", data_sram_addr, expAddr);
         checkOutput("wait_stall", {31'h0, stallreq}, 32'h1);
         checkOutput("wait_resp", {31'h0, resp_valid}, 32'h0);
         @(posedge clk); #1;
      end
      data_sram_addr_ok = 1'b1;
      data_sram_data_ok = (dokDelay == 0);
      data_sram_rdata   = (dokDelay == 0) ? raw : $urandom;
      @(negedge clk);
      checkOutput("addr_en", {31'h0, data_sram_en}, 32'h1);
      checkOutput("addr_wen", {28'h0, data_sram_wen}, {28'h0, expWen});
      checkOutput("addr_addr", data_sram_addr, expAddr);
      if (wr) checkOutput("addr_wdata", data_sram_wdata, expWd);
      checkOutput("addr_stall", {31'h0, stallreq}, 32'h1);
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      for (int i = 1; i <= dokDelay; i++) begin
         data_sram_data_ok = (i == dokDelay);
         data_sram_rdata   = (i == dokDelay) ? raw : $urandom;
         @(negedge clk);
         checkOutput("data_en_low", {31'h0, data_sram_en}, 32'h0);
         checkOutput("data_stall", {31'h0, stallreq}, 32'h1);
         checkOutput("data_resp", {31'h0, resp_valid}, 32'h0);
         @(posedge clk); #1;
         data_sram_data_ok = 1'b0;
      end
      data_sram_rdata = $urandom;
      @(negedge clk);
      checkOutput("resp_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("resp_rdata", resp_rdata, expRd);
      checkOutput("resp_stall", {31'h0, stallreq}, 32'h0);
      checkOutput("resp_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("after_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("after_resp_stall", {31'h0, stallreq}, 32'h0);
      checkOutput("after_resp_en", {31'h0, data_sram_en}, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_en", {31'h0, data_sram_en}, 32'h0);
      checkOutput("rst_wen", {28'h0, data_sram_wen}, 32'h0);
      checkOutput("rst_addr", data_sram_addr, 32'h0);
      checkOutput("rst_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("rst_rdata", resp_rdata, 32'h0);
      checkOutput("rst_stall", {31'h0, stallreq}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed accesses");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8011_2233, 3, 2);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'hABCD_1234, 1, 1);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_5678, 32'h0, 0, 1);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 0);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0304, 32'h0102_0304, 32'h0, 2, 0);

      $display("[TB] reset during data phase");
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0040;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b1;
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midrst_en", {31'h0, data_sram_en}, 32'h0);
      checkOutput("midrst_wen", {28'h0, data_sram_wen}, 32'h0);
      checkOutput("midrst_addr", data_sram_addr, 32'h0);
      checkOutput("midrst_wdata", data_sram_wdata, 32'h0);
      checkOutput("midrst_resp", {31'h0, resp_valid}, 32'h0);
      checkOutput("midrst_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555_AAAA;
      @(negedge clk);
      checkOutput("stale_ok_resp", {31'h0, resp_valid}, 32'h0);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      checkOutput("stale_ok_resp2", {31'h0, resp_valid}, 32'h0);
      checkOutput("stale_ok_en", {31'h0, data_sram_en}, 32'h0);
      @(posedge clk); #1;

      $display("[TB] randomized accesses");
      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
